// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one breadboard ALU between two requesters.
// Operations are granted round-robin over valid/ready handshakes.
// An optional lock keeps accumulator-chained sequences on one requester.
// Each grant is issued to the ALU for one cycle, then held for LAT wait cycles.
// The accumulator and error flags are then captured into a tagged response.
module alu_arbiter #(
  parameter int N        = 16,
  parameter int LAT      = 1,
  parameter int MAX_LOCK = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [4:0]       req0_cmd,
  input  logic [N-1:0]     req0_a,
  input  logic [N-1:0]     req0_b,
  input  logic             req0_lock,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [4:0]       req1_cmd,
  input  logic [N-1:0]     req1_a,
  input  logic [N-1:0]     req1_b,
  input  logic             req1_lock,
  output logic [N-1:0]     alu_A,
  output logic [N-1:0]     alu_B,
  output logic [4:0]       alu_CMD,
  output logic             alu_noOp,
  output logic             alu_RST,
  input  logic [2*N-1:0]   alu_AcumOut,
  input  logic             alu_overflow,
  input  logic             alu_divByZero,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [2*N-1:0]   rsp_data,
  output logic             rsp_ovf,
  output logic             rsp_dbz,
  output logic             busy
);

  localparam int LCW        = $clog2(MAX_LOCK + 1);
  localparam int WCW        = (LAT > 1) ? $clog2(LAT + 1) : 1;
  localparam int IDLE_LIMIT = 4;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t           state_q, state_d;
  logic [4:0]       cmd_q, cmd_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic             lock_q, lock_d;
  logic             owner_q, owner_d;
  logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [2:0]       idle_cnt_q, idle_cnt_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [2*N-1:0]   rsp_data_q, rsp_data_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             rsp_dbz_q, rsp_dbz_d;

  logic             grant_valid;
  logic             grant_id;
  logic             grant_lock;
  logic             idle_open;
  logic             handshake;
  logic             owner_valid;
  logic [LCW-1:0]   lock_cnt_next;

  // Pick the winner: the lock owner only, otherwise a lone requester or the one not served last.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (lock_q) begin
      grant_valid = owner_q ? req1_valid : req0_valid;
      grant_id    = owner_q;
    end else if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = ~last_q;
    end else if (req0_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  assign idle_open   = (state_q == S_IDLE) && !RST;
  assign handshake   = idle_open && grant_valid;
  assign req0_ready  = handshake && !grant_id;
  assign req1_ready  = handshake && grant_id;
  assign grant_lock  = grant_id ? req1_lock : req0_lock;
  assign owner_valid = owner_q ? req1_valid : req0_valid;

  // Sequencer next state: latch grants, run the issue/wait timing, capture results, track the lock.
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    a_d           = a_q;
    b_d           = b_q;
    id_d          = id_q;
    last_d        = last_q;
    lock_d        = lock_q;
    owner_d       = owner_q;
    lock_cnt_d    = lock_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    rsp_valid_d   = 1'b0;
    rsp_id_d      = rsp_id_q;
    rsp_data_d    = rsp_data_q;
    rsp_ovf_d     = rsp_ovf_q;
    rsp_dbz_d     = rsp_dbz_q;
    lock_cnt_next = '0;
    case (state_q)
      S_INIT: begin
        state_d = S_IDLE;
      end
      S_IDLE: begin
        if (handshake) begin
          cmd_d      = grant_id ? req1_cmd : req0_cmd;
          a_d        = grant_id ? req1_a : req0_a;
          b_d        = grant_id ? req1_b : req0_b;
          id_d       = grant_id;
          last_d     = grant_id;
          idle_cnt_d = '0;
          state_d    = S_ISSUE;
          if (grant_lock) begin
            lock_cnt_next = (lock_q && (owner_q == grant_id)) ? lock_cnt_q + 1'b1 : LCW'(1);
            if (lock_cnt_next >= LCW'(MAX_LOCK)) begin
              lock_d     = 1'b0;
              lock_cnt_d = '0;
            end else begin
              lock_d     = 1'b1;
              owner_d    = grant_id;
              lock_cnt_d = lock_cnt_next;
            end
          end else begin
            lock_d     = 1'b0;
            lock_cnt_d = '0;
          end
        end else if (lock_q && !owner_valid) begin
          if (idle_cnt_q == 3'(IDLE_LIMIT - 1)) begin
            lock_d     = 1'b0;
            lock_cnt_d = '0;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end else begin
          idle_cnt_d = '0;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = WCW'(LAT);
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q <= WCW'(1)) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = alu_AcumOut;
          rsp_ovf_d   = alu_overflow;
          rsp_dbz_d   = alu_divByZero;
          state_d     = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // State registers with synchronous reset; the pointer favours req0 after reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_INIT;
      cmd_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      lock_q      <= 1'b0;
      owner_q     <= 1'b0;
      lock_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_dbz_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      last_q      <= last_d;
      lock_q      <= lock_d;
      owner_q     <= owner_d;
      lock_cnt_q  <= lock_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_dbz_q   <= rsp_dbz_d;
    end
  end

  // Operands come straight from the holding registers, so they stay put through WAIT.
  assign alu_A    = a_q;
  assign alu_B    = b_q;
  assign alu_CMD  = cmd_q;
  assign alu_RST  = RST || (state_q == S_INIT);
  assign alu_noOp = RST || !((state_q == S_INIT) || (state_q == S_ISSUE));
  assign busy     = (state_q == S_ISSUE) || (state_q == S_WAIT);

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_dbz   = rsp_dbz_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural breadboard ALU model.
module tb_alu_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_cmd, req1_cmd;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_lock, req1_lock;
  logic [15:0] alu_A, alu_B;
  logic [4:0]  alu_CMD;
  logic        alu_noOp, alu_RST;
  logic [31:0] alu_AcumOut;
  logic        alu_overflow, alu_divByZero;
  logic        rsp_valid, rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_ovf, rsp_dbz, busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] alu_acc;
  logic [31:0] alu_opb;
  logic [31:0] alu_sum;
  logic [31:0] alu_quo;

  alu_arbiter #(.N(16), .LAT(1), .MAX_LOCK(4)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
    .req0_a(req0_a), .req0_b(req0_b), .req0_lock(req0_lock),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
    .req1_a(req1_a), .req1_b(req1_b), .req1_lock(req1_lock),
    .alu_A(alu_A), .alu_B(alu_B), .alu_CMD(alu_CMD), .alu_noOp(alu_noOp),
    .alu_RST(alu_RST), .alu_AcumOut(alu_AcumOut), .alu_overflow(alu_overflow),
    .alu_divByZero(alu_divByZero),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ovf(rsp_ovf), .rsp_dbz(rsp_dbz), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Breadboard ALU model: add (00001) and divide (00100); cmd bit 4 takes B from the accumulator.
  assign alu_opb = alu_CMD[4] ? alu_acc : {16'b0, alu_B};
  assign alu_sum = {16'b0, alu_A} + alu_opb;
  assign alu_quo = (alu_opb == 32'd0) ? 32'd0 : ({16'b0, alu_A} / alu_opb);
  assign alu_AcumOut = alu_acc;

  // Accumulator and flags update only when the arbiter lets the ALU run.
  always @(posedge CLK) begin
    if (alu_RST) begin
      alu_acc       <= 32'd0;
      alu_overflow  <= 1'b0;
      alu_divByZero <= 1'b0;
    end else if (!alu_noOp) begin
      case (alu_CMD[3:0])
        4'd1: begin
          alu_acc       <= alu_sum;
          alu_overflow  <= |alu_sum[31:16];
          alu_divByZero <= 1'b0;
        end
        4'd4: begin
          alu_acc       <= alu_quo;
          alu_overflow  <= 1'b0;
          alu_divByZero <= (alu_opb == 32'd0);
        end
        default: begin
          alu_overflow  <= 1'b0;
          alu_divByZero <= 1'b0;
        end
      endcase
    end
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cycle();
    @(posedge CLK);
    #2;
  endtask

  task automatic applyStimulus(
    input logic v0, input logic [4:0] c0, input logic [15:0] a0, input logic [15:0] b0, input logic l0,
    input logic v1, input logic [4:0] c1, input logic [15:0] a1, input logic [15:0] b1, input logic l1);
    req0_valid = v0; req0_cmd = c0; req0_a = a0; req0_b = b0; req0_lock = l0;
    req1_valid = v1; req1_cmd = c1; req1_a = a1; req1_b = b1; req1_lock = l1;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkFlag(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  initial begin
    $display("[TB] alu_arbiter directed test start");
    RST = 1'b1;
    applyStimulus(1'b1, 5'b00001, 16'd10, 16'd20, 1'b0, 1'b0, 5'b0, 16'd0, 16'd0, 1'b0);

    // Reset held for two cycles
    cycle(); cycle();
    checkFlag("rst_ready0", req0_ready, 1'b0);
    checkFlag("rst_alu_rst", alu_RST, 1'b1);
    checkFlag("rst_noop", alu_noOp, 1'b1);
    checkFlag("rst_busy", busy, 1'b0);
    checkFlag("rst_rsp_valid", rsp_valid, 1'b0);
    checkOutput("rst_alu_a", 32'(alu_A), 32'd0);
    checkOutput("rst_alu_cmd", 32'(alu_CMD), 32'd0);
    checkOutput("rst_rsp_data", rsp_data, 32'd0);

    // INIT cycle
    RST = 1'b0;
    #1;
    checkFlag("init_alu_rst", alu_RST, 1'b1);
    checkFlag("init_noop", alu_noOp, 1'b0);
    checkFlag("init_ready0", req0_ready, 1'b0);

    // Single op: handshake in the first IDLE cycle
    cycle();
    checkFlag("idle_alu_rst", alu_RST, 1'b0);
    checkFlag("idle_noop", alu_noOp, 1'b1);
    checkFlag("single_ready0", req0_ready, 1'b1);
    checkFlag("single_ready1", req1_ready, 1'b0);
    cycle();
    applyStimulus(1'b0, 5'b0, 16'd0, 16'd0, 1'b0, 1'b0, 5'b0, 16'd0, 16'd0, 1'b0);
    checkFlag("issue_noop", alu_noOp, 1'b0);
    checkOutput("issue_cmd", 32'(alu_CMD), 32'd1);
    checkOutput("issue_a", 32'(alu_A), 32'd10);
    checkOutput("issue_b", 32'(alu_B), 32'd20);
    checkFlag("issue_busy", busy, 1'b1);
    cycle();
    checkFlag("wait_noop", alu_noOp, 1'b1);
    checkOutput("wait_a_held", 32'(alu_A), 32'd10);
    checkFlag("wait_rsp_valid", rsp_valid, 1'b0);
    checkFlag("wait_busy", busy, 1'b1);
    cycle();
    checkFlag("single_rsp_valid", rsp_valid, 1'b1);
    checkOutput("single_rsp_data", rsp_data, 32'd30);
    checkFlag("single_rsp_id", rsp_id, 1'b0);
    checkFlag("single_rsp_ovf", rsp_ovf, 1'b0);
    checkFlag("single_busy", busy, 1'b0);
    cycle();
    checkFlag("single_pulse_end", rsp_valid, 1'b0);
    checkOutput("single_data_hold", rsp_data, 32'd30);

    // Contention right after a fresh reset
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    cycle();
    applyStimulus(1'b1, 5'b00001, 16'd1, 16'd2, 1'b0, 1'b1, 5'b00001, 16'd100, 16'd200, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checkFlag("cont_ready0", req0_ready, (k % 2) == 0);
      checkFlag("cont_ready1", req1_ready, (k % 2) == 1);
      checkFlag("cont_rsp_valid", rsp_valid, k > 0);
      if (k > 0) begin
        checkFlag("cont_rsp_id", rsp_id, 1'((k - 1) % 2));
        checkOutput("cont_rsp_data", rsp_data, ((k - 1) % 2 == 0) ? 32'd3 : 32'd300);
      end
      cycle();
      checkOutput("cont_issue_a", 32'(alu_A), ((k % 2) == 0) ? 32'd1 : 32'd100);
      cycle(); cycle();
    end
    checkFlag("cont_last_valid", rsp_valid, 1'b1);
    checkFlag("cont_last_id", rsp_id, 1'b1);
    checkOutput("cont_last_data", rsp_data, 32'd300);
    applyStimulus(1'b0, 5'b0, 16'd0, 16'd0, 1'b0, 1'b0, 5'b0, 16'd0, 16'd0, 1'b0);
    cycle();

    // Lock chain: req0 locked add, then accumulator divide, req1 waiting throughout
    applyStimulus(1'b1, 5'b00001, 16'd10, 16'd20, 1'b1, 1'b1, 5'b00001, 16'd7, 16'd8, 1'b0);
    checkFlag("lock_first_ready0", req0_ready, 1'b1);
    checkFlag("lock_first_ready1", req1_ready, 1'b0);
    cycle();
    applyStimulus(1'b1, 5'b10100, 16'd90, 16'd0, 1'b0, 1'b1, 5'b00001, 16'd7, 16'd8, 1'b0);
    cycle(); cycle();
    checkOutput("lock_rsp1_data", rsp_data, 32'd30);
    checkFlag("lock_hold_ready0", req0_ready, 1'b1);
    checkFlag("lock_hold_ready1", req1_ready, 1'b0);
    cycle();
    checkOutput("lock_issue_cmd", 32'(alu_CMD), 32'd20);
    checkOutput("lock_issue_a", 32'(alu_A), 32'd90);
    applyStimulus(1'b0, 5'b0, 16'd0, 16'd0, 1'b0, 1'b1, 5'b00001, 16'd7, 16'd8, 1'b0);
    cycle(); cycle();
    checkFlag("lock_rsp2_valid", rsp_valid, 1'b1);
    checkOutput("lock_rsp2_data", rsp_data, 32'd3);
    checkFlag("lock_rsp2_id", rsp_id, 1'b0);
    checkFlag("unlock_ready1", req1_ready, 1'b1);
    cycle(); cycle(); cycle();
    checkFlag("unlock_rsp_id", rsp_id, 1'b1);
    checkOutput("unlock_rsp_data", rsp_data, 32'd15);

    // MAX_LOCK: four locked grants in a row, then req1 gets in
    applyStimulus(1'b1, 5'b00001, 16'd1, 16'd1, 1'b1, 1'b1, 5'b00001, 16'd7, 16'd8, 1'b0);
    for (int g = 0; g < 4; g++) begin
      checkFlag("maxlock_ready0", req0_ready, 1'b1);
      checkFlag("maxlock_ready1", req1_ready, 1'b0);
      cycle(); cycle(); cycle();
    end
    checkFlag("maxlock_release_ready1", req1_ready, 1'b1);
    checkFlag("maxlock_release_ready0", req0_ready, 1'b0);
    checkFlag("maxlock_rsp_id", rsp_id, 1'b0);
    checkOutput("maxlock_rsp_data", rsp_data, 32'd2);
    applyStimulus(1'b0, 5'b0, 16'd0, 16'd0, 1'b0, 1'b1, 5'b00001, 16'd7, 16'd8, 1'b0);
    cycle();
    applyStimulus(1'b0, 5'b0, 16'd0, 16'd0, 1'b0, 1'b0, 5'b0, 16'd0, 16'd0, 1'b0);
    cycle(); cycle();
    checkFlag("maxlock_req1_rsp_id", rsp_id, 1'b1);

    // Idle release: owner stays quiet for four IDLE cycles
    applyStimulus(1'b1, 5'b00001, 16'd2, 16'd3, 1'b1, 1'b0, 5'b0, 16'd0, 16'd0, 1'b0);
    checkFlag("idle_lock_ready0", req0_ready, 1'b1);
    cycle();
    applyStimulus(1'b0, 5'b0, 16'd0, 16'd0, 1'b0, 1'b1, 5'b00001, 16'd7, 16'd8, 1'b0);
    cycle(); cycle();
    checkOutput("idle_lock_rsp_data", rsp_data, 32'd5);
    checkFlag("idle1_ready1", req1_ready, 1'b0);
    cycle(); cycle(); cycle();
    checkFlag("idle4_ready1", req1_ready, 1'b0);
    cycle();
    applyStimulus(1'b0, 5'b0, 16'd0, 16'd0, 1'b0, 1'b1, 5'b00100, 16'd5, 16'd0, 1'b0);
    checkFlag("idle5_ready1", req1_ready, 1'b1);

    // Errors: divide by zero from req1, then an overflowing add from req0
    cycle();
    applyStimulus(1'b0, 5'b0, 16'd0, 16'd0, 1'b0, 1'b0, 5'b0, 16'd0, 16'd0, 1'b0);
    cycle(); cycle();
    checkFlag("dbz_flag", rsp_dbz, 1'b1);
    checkFlag("dbz_id", rsp_id, 1'b1);
    checkFlag("dbz_ovf", rsp_ovf, 1'b0);
    applyStimulus(1'b1, 5'b00001, 16'd60000, 16'd6000, 1'b0, 1'b0, 5'b0, 16'd0, 16'd0, 1'b0);
    checkFlag("ovf_ready0", req0_ready, 1'b1);
    cycle();
    applyStimulus(1'b0, 5'b0, 16'd0, 16'd0, 1'b0, 1'b0, 5'b0, 16'd0, 16'd0, 1'b0);
    cycle(); cycle();
    checkFlag("ovf_flag", rsp_ovf, 1'b1);
    checkOutput("ovf_data", rsp_data, 32'd66000);
    checkFlag("ovf_dbz_clear", rsp_dbz, 1'b0);
    checkFlag("ovf_id", rsp_id, 1'b0);

    // Reset asserted during WAIT drops the in-flight op
    applyStimulus(1'b1, 5'b00001, 16'd3, 16'd4, 1'b0, 1'b0, 5'b0, 16'd0, 16'd0, 1'b0);
    cycle();
    applyStimulus(1'b0, 5'b0, 16'd0, 16'd0, 1'b0, 1'b0, 5'b0, 16'd0, 16'd0, 1'b0);
    cycle();
    checkFlag("midrst_wait_busy", busy, 1'b1);
    RST = 1'b1;
    cycle();
    checkFlag("midrst_rsp_valid", rsp_valid, 1'b0);
    checkFlag("midrst_busy", busy, 1'b0);
    checkFlag("midrst_alu_rst", alu_RST, 1'b1);
    checkOutput("midrst_rsp_data", rsp_data, 32'd0);
    RST = 1'b0;
    applyStimulus(1'b1, 5'b00001, 16'd3, 16'd4, 1'b0, 1'b0, 5'b0, 16'd0, 16'd0, 1'b0);
    checkFlag("midrst_init_noop", alu_noOp, 1'b0);
    checkFlag("midrst_init_ready0", req0_ready, 1'b0);
    cycle();
    checkFlag("midrst_idle_ready0", req0_ready, 1'b1);
    cycle();
    applyStimulus(1'b0, 5'b0, 16'd0, 16'd0, 1'b0, 1'b0, 5'b0, 16'd0, 16'd0, 1'b0);
    cycle(); cycle();
    checkFlag("after_rst_valid", rsp_valid, 1'b1);
    checkOutput("after_rst_data", rsp_data, 32'd7);
    checkFlag("after_rst_id", rsp_id, 1'b0);
    cycle();
    checkFlag("after_rst_pulse_end", rsp_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port request arbiter and sequencer that shares one `breadboard` ALU between two requesters. It accepts `{cmd, a, b}` operations over valid/ready handshakes and grants them round-robin, with an optional lock for accumulator-chained sequences. It drives the ALU's `A`/`B`/`CMD`/`noOp`/`RST` inputs, samples `AcumOut` and the error flags after a fixed latency, and returns a tagged response. It sits between the requesting controllers and the ALU breadboard.

## Interface
- `N`, 16: operand width; the result is 2N bits.
- `LAT`, 1: WAIT cycles between the ISSUE cycle and result capture (≥1).
- `MAX_LOCK`, 4: maximum consecutive locked grants to one requester.

- `CLK`  in  1  clock; all state updates on posedge.
- `RST`  in  1  synchronous, active-high reset.
- `req0_valid`, `req1_valid`  in  1  request present.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle when valid&ready.
- `req0_cmd`, `req1_cmd`  in  5  ALU opcode; bit 4 = B operand taken from the accumulator.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  N  operands.
- `req0_lock`, `req1_lock`  in  1  keep the grant for this requester's next request.
- `alu_A`, `alu_B`  out  N  ALU operands.
- `alu_CMD`  out  5  ALU command.
- `alu_noOp`  out  1  1 = ALU holds its registers.
- `alu_RST`  out  1  ALU register clear.
- `alu_AcumOut`  in  2N  ALU accumulator.
- `alu_overflow`, `alu_divByZero`  in  1  ALU error flags.
- `rsp_valid`  out  1  one-cycle result pulse; no backpressure.
- `rsp_id`  out  1  requester index of the result.
- `rsp_data`  out  2N  captured `alu_AcumOut`.
- `rsp_ovf`, `rsp_dbz`  out  1  captured error flags.
- `busy`  out  1  high in ISSUE/WAIT.

## Operation
- States: INIT, IDLE, ISSUE, WAIT.
- `RST`=1 in any state:
  - next state INIT;
  - clears holding registers, lock, lock counter and idle counter;
  - round-robin pointer favours req0.
- INIT:
  - `alu_RST`=1, `alu_noOp`=0, both readys low;
  - lasts one cycle after `RST` falls, then IDLE.
- IDLE:
  - `alu_noOp`=1;
  - grant is combinational. Unlocked: the single valid requester wins. If both are valid, the one not granted last wins.
  - Only the winner's ready is high.
  - On handshake, latch cmd/a/b/lock/id into holding registers → ISSUE.
- ISSUE, exactly one cycle:
  - `alu_A`/`alu_B`/`alu_CMD` = holding registers, `alu_noOp`=0;
  - WAIT counter loaded with LAT.
- WAIT:
  - `alu_noOp`=1; ALU operand outputs held at their ISSUE values;
  - counter decrements each cycle.
  - On the edge ending the last WAIT cycle: `rsp_data`←`alu_AcumOut`, `rsp_ovf`←`alu_overflow`, `rsp_dbz`←`alu_divByZero`, `rsp_id`←holding id, `rsp_valid`←1 → IDLE.
- Lock:
  - A grant with lock=1 makes that requester owner; the other requester's ready is forced low.
  - Lock is released when:
    - the owner issues with lock=0;
    - the owner issues its MAX_LOCK-th consecutive locked grant, which is treated as unlocked;
    - the owner's valid is low for 4 consecutive IDLE cycles.
  - After release, normal round-robin resumes; the pointer records the owner as last granted.
- Width: the ALU computes at 2N. The block does no arithmetic; it passes values through unmodified.

## Timing
- Reset values:
  - readys 0;
  - `alu_A`=0, `alu_B`=0, `alu_CMD`=0, `alu_noOp`=1, `alu_RST`=1;
  - all `rsp_*` 0, `busy` 0.
- Latency: handshake in cycle t → ISSUE t+1 → WAIT t+2..t+1+LAT → `rsp_valid` in cycle t+2+LAT.
- The `rsp_valid` cycle is an IDLE cycle; a new handshake is allowed in it.
- Throughput: one op per LAT+2 cycles.
- `rsp_valid` is high for exactly one cycle. `rsp_data`/`rsp_id`/`rsp_ovf`/`rsp_dbz` hold until the next capture.
- `RST` during ISSUE or WAIT: the in-flight op produces no response, and `rsp_valid` is 0 in the following cycle.
- Simultaneous valid from the owner and a non-owner under lock: the owner always wins.

## Test plan
- Reset: `RST` high for 2 cycles, then low.
  - `alu_RST`=1 through the INIT cycle; `alu_noOp`=1 in IDLE.
  - `rsp_valid`=0 and both readys 0 until IDLE.
- Single op: req0 add (00001), A=10, B=20, LAT=1, handshake at t.
  - `alu_noOp`=0 and `alu_CMD`=00001 at t+1.
  - `rsp_valid`=1 at t+3 with `rsp_data`=30, `rsp_id`=0.
- Contention: both requesters continuously valid, no lock, first grant after reset.
  - Grants alternate 0,1,0,1.
  - `rsp_id` sequence 0,1,0,1 at 3-cycle spacing.
- Lock chain, with req1 valid throughout:
  - req0 lock=1 add 10+20, then lock=0 cmd 10100 with A=90 → `rsp_data`=3 on the second response.
  - req1 is granted only after req0's lock=0 issue.
  - Separately: req0 locks MAX_LOCK=4 times in a row → req1 is granted next.
- Errors:
  - req1 div (00100), A=5, B=0 → `rsp_dbz`=1, `rsp_id`=1.
  - add 60000+6000 → `rsp_ovf` equals the sampled `alu_overflow`.
- Reset mid-op: `RST` asserted in the WAIT cycle → no `rsp_valid`, INIT next, `busy`=0.
  - A new request then completes normally.
